// File: rtl/instr_stream_encoder.sv
// rtl/instr_stream_encoder.sv - encodes symbolic commands into MIPS words and loads them into instruction memory
//
// Purpose: accepts one command per cycle during a load session, encodes it
// into a 32-bit MIPS instruction word and issues a registered single-cycle
// write to instruction memory. The core is held off (core_load_en low) until
// a HALT is written or the memory is full.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start                 pulse: begin a load session (ignored while loading)
//   cmd_valid/cmd_ready   command handshake
//   cmd_kind..cmd_target  symbolic command fields
//   imem_we/addr/wdata    instruction-memory write port
//   busy, done            session status
//   core_load_en          high when the core may run (IDLE/DONE)
//   illegal_err           sticky: illegal kind accepted this session
//   overflow_err          sticky: capacity reached before HALT
//   instr_count           words written this session
module instr_stream_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_kind,
  input  logic [4:0]        cmd_rs,
  input  logic [4:0]        cmd_rt,
  input  logic [4:0]        cmd_rd,
  input  logic [4:0]        cmd_shamt,
  input  logic [5:0]        cmd_funct,
  input  logic [15:0]       cmd_imm,
  input  logic [25:0]       cmd_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              core_load_en,
  output logic              illegal_err,
  output logic              overflow_err,
  output logic [ADDR_W:0]   instr_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(BASE_ADDR + DEPTH - 1);

  localparam logic [3:0] K_RTYPE = 4'd0;
  localparam logic [3:0] K_LW    = 4'd1;
  localparam logic [3:0] K_SW    = 4'd2;
  localparam logic [3:0] K_BEQ   = 4'd3;
  localparam logic [3:0] K_ADDI  = 4'd4;
  localparam logic [3:0] K_J     = 4'd5;
  localparam logic [3:0] K_JAL   = 4'd6;
  localparam logic [3:0] K_JR    = 4'd7;
  localparam logic [3:0] K_JALR  = 4'd8;
  localparam logic [3:0] K_HALT  = 4'd9;

  localparam logic [31:0] WORD_HALT = 32'hFC00_0000;
  localparam logic [31:0] WORD_NOP  = 32'h0000_0000;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                ill_q, ill_d;
  logic                ovf_q, ovf_d;

  logic                accept;
  logic                is_halt;
  logic                last_slot;
  logic                force_halt;
  logic [31:0]         enc_word;

  assign accept     = cmd_valid && (state_q == ST_LOAD);
  assign is_halt    = (cmd_kind == K_HALT);
  assign last_slot  = (ptr_q == LAST_ADDR);
  // The final slot must always end the program, so anything but HALT is replaced.
  assign force_halt = last_slot && !is_halt;

  // Field packing; unused fields of each kind are tied to zero.
  always_comb begin
    enc_word = WORD_NOP;
    case (cmd_kind)
      K_RTYPE: enc_word = {6'b000000, cmd_rs, cmd_rt, cmd_rd, cmd_shamt, cmd_funct};
      K_LW:    enc_word = {6'b100011, cmd_rs, cmd_rt, cmd_imm};
      K_SW:    enc_word = {6'b101011, cmd_rs, cmd_rt, cmd_imm};
      K_BEQ:   enc_word = {6'b000100, cmd_rs, cmd_rt, cmd_imm};
      K_ADDI:  enc_word = {6'b001000, cmd_rs, cmd_rt, cmd_imm};
      K_J:     enc_word = {6'b000010, cmd_target};
      K_JAL:   enc_word = {6'b000011, cmd_target};
      K_JR:    enc_word = {6'b000000, cmd_rs, 15'd0, 6'b001000};
      K_JALR:  enc_word = {6'b000000, cmd_rs, 5'd0, 5'd31, 5'd0, 6'b001001};
      K_HALT:  enc_word = WORD_HALT;
      default: enc_word = WORD_NOP;
    endcase
  end

  // State register and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= FIRST_ADDR;
      we_q    <= 1'b0;
      addr_q  <= FIRST_ADDR;
      wdata_q <= '0;
      count_q <= '0;
      ill_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      ill_q   <= ill_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: if (accept && (is_halt || last_slot)) state_d = ST_DONE;
      ST_DONE: if (start) state_d = ST_LOAD;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    ptr_d   = ptr_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    ill_d   = ill_q;
    ovf_d   = ovf_q;
    if ((state_q != ST_LOAD) && start) begin
      ptr_d   = FIRST_ADDR;
      count_d = '0;
      ill_d   = 1'b0;
      ovf_d   = 1'b0;
    end else if (accept) begin
      we_d    = 1'b1;
      addr_d  = ptr_q;
      wdata_d = force_halt ? WORD_HALT : enc_word;
      ptr_d   = ptr_q + 1'b1;
      count_d = count_q + 1'b1;
      if (cmd_kind > K_HALT) ill_d = 1'b1;
      if (force_halt) ovf_d = 1'b1;
    end
  end

  // Outputs
  always_comb begin
    cmd_ready    = (state_q == ST_LOAD);
    busy         = (state_q == ST_LOAD);
    done         = (state_q == ST_DONE);
    core_load_en = (state_q != ST_LOAD);
    imem_we      = we_q;
    imem_addr    = addr_q;
    imem_wdata   = wdata_q;
    instr_count  = count_q;
    illegal_err  = ill_q;
    overflow_err = ovf_q;
  end

endmodule

// File: tb/tb_instr_stream_encoder.sv
// tb/tb_instr_stream_encoder.sv - scoreboard bench for instr_stream_encoder
module tb_instr_stream_encoder;

  localparam int ADDR_W    = 8;
  localparam int BASE_ADDR = 0;
  localparam int DEPTH     = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_kind;
  logic [4:0]        cmd_rs, cmd_rt, cmd_rd, cmd_shamt;
  logic [5:0]        cmd_funct;
  logic [15:0]       cmd_imm;
  logic [25:0]       cmd_target;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              busy, done, core_load_en, illegal_err, overflow_err;
  logic [ADDR_W:0]   instr_count;

  instr_stream_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_kind(cmd_kind), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
    .cmd_shamt(cmd_shamt), .cmd_funct(cmd_funct), .cmd_imm(cmd_imm), .cmd_target(cmd_target),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .core_load_en(core_load_en),
    .illegal_err(illegal_err), .overflow_err(overflow_err), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  kind;
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [25:0] tgt;
  } cmd_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       word;
    int                cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Reference model: session state 0 idle, 1 loading, 2 done
  int   m_state = 0;
  int   m_slot = 0;
  int   m_count = 0;
  bit   m_ill = 0;
  bit   m_ovf = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_word(input cmd_t c);
    case (c.kind)
      4'd0: return {6'd0, c.rs, c.rt, c.rd, c.sh, c.fn};
      4'd1: return {6'h23, c.rs, c.rt, c.imm};
      4'd2: return {6'h2B, c.rs, c.rt, c.imm};
      4'd3: return {6'h04, c.rs, c.rt, c.imm};
      4'd4: return {6'h08, c.rs, c.rt, c.imm};
      4'd5: return {6'h02, c.tgt};
      4'd6: return {6'h03, c.tgt};
      4'd7: return {6'd0, c.rs, 15'd0, 6'h08};
      4'd8: return {6'd0, c.rs, 5'd0, 5'd31, 5'd0, 6'h09};
      4'd9: return 32'hFC00_0000;
      default: return 32'h0;
    endcase
  endfunction

  // Monitor: every write must match the oldest expected entry
  always @(negedge clk) begin
    if (rst_n === 1'b1 && imem_we === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%08h with nothing expected", imem_addr, imem_wdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("write_addr", 32'(imem_addr), 32'(e.addr));
        chk("write_data", imem_wdata, e.word);
        chk("write_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  function automatic cmd_t rand_cmd(input logic [3:0] kind);
    cmd_t c;
    c.kind = kind;
    c.rs   = 5'($urandom);
    c.rt   = 5'($urandom);
    c.rd   = 5'($urandom);
    c.sh   = 5'($urandom);
    c.fn   = 6'($urandom);
    c.imm  = 16'($urandom);
    c.tgt  = 26'($urandom);
    return c;
  endfunction

  function automatic cmd_t mk(input logic [3:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [5:0] fn, input logic [15:0] imm,
                              input logic [25:0] tgt);
    cmd_t c;
    c = rand_cmd(kind);
    c.rs = rs; c.rt = rt; c.rd = rd; c.sh = 5'd0; c.fn = fn; c.imm = imm; c.tgt = tgt;
    return c;
  endfunction

  task automatic drive(input cmd_t c);
    cmd_kind = c.kind; cmd_rs = c.rs; cmd_rt = c.rt; cmd_rd = c.rd;
    cmd_shamt = c.sh; cmd_funct = c.fn; cmd_imm = c.imm; cmd_target = c.tgt;
  endtask

  task automatic model_accept(input cmd_t c, input bit use_lit, input logic [31:0] lit);
    exp_t e;
    logic [31:0] w;
    w = use_lit ? lit : ref_word(c);
    if (c.kind > 4'd9) m_ill = 1;
    if (c.kind == 4'd9) begin
      m_state = 2;
    end else if (m_slot == DEPTH - 1) begin
      w = 32'hFC00_0000;
      m_ovf = 1;
      m_state = 2;
    end
    e.addr = ADDR_W'(BASE_ADDR + m_slot);
    e.word = w;
    e.cyc  = cyc + 1;
    sb.push_back(e);
    m_slot++;
    m_count++;
  endtask

  task automatic send(input cmd_t c, input bit use_lit, input logic [31:0] lit);
    int waited;
    waited = 0;
    @(negedge clk);
    drive(c);
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (cmd_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL cmd_ready_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, waited);
      cmd_valid = 1'b0;
      return;
    end
    model_accept(c, use_lit, lit);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    if (m_state != 1) begin
      m_state = 1; m_slot = 0; m_count = 0; m_ill = 0; m_ovf = 0;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_status(input string tag);
    chk({tag, ".done"},         32'(done),         32'(m_state == 2));
    chk({tag, ".busy"},         32'(busy),         32'(m_state == 1));
    chk({tag, ".core_load_en"}, 32'(core_load_en), 32'(m_state != 1));
    chk({tag, ".cmd_ready"},    32'(cmd_ready),    32'(m_state == 1));
    chk({tag, ".instr_count"},  32'(instr_count),  32'(m_count));
    chk({tag, ".illegal_err"},  32'(illegal_err),  32'(m_ill));
    chk({tag, ".overflow_err"}, 32'(overflow_err), 32'(m_ovf));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    cmd_t c;
    rst_n = 1'b0; start = 1'b0; cmd_valid = 1'b0;
    drive(rand_cmd(4'd0));
    repeat (3) @(negedge clk);
    check_status("reset");
    chk("reset.imem_we",    32'(imem_we),    32'd0);
    chk("reset.imem_addr",  32'(imem_addr),  32'(BASE_ADDR));
    chk("reset.imem_wdata", imem_wdata,      32'd0);
    rst_n = 1'b1;

    // ADDI / LW / HALT back-to-back
    pulse_start();
    send(mk(4'd4, 5'd1, 5'd2, 5'd9, 6'h3F, 16'd5, 26'h3FFFFFF), 1, 32'h2022_0005);
    send(mk(4'd1, 5'd29, 5'd8, 5'd0, 6'd0, 16'd4, 26'd0), 1, 32'h8FA8_0004);
    send(mk(4'd9, 5'd7, 5'd7, 5'd7, 6'h3F, 16'hFFFF, 26'h155), 1, 32'hFC00_0000);
    @(negedge clk);
    check_status("s1");

    // RTYPE and BEQ with junk in unused fields
    pulse_start();
    send(mk(4'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'hFFFF, 26'h3FFFFFF), 1, 32'h0022_1820);
    c = mk(4'd3, 5'd1, 5'd2, 5'd7, 6'h3F, 16'hFFFF, 26'h2AAAAAA);
    c.sh = 5'd3;
    send(c, 1, 32'h1022_FFFF);
    send(rand_cmd(4'd9), 1, 32'hFC00_0000);
    @(negedge clk);
    check_status("s2");

    // Jumps; HALT lands exactly in the last slot without error
    pulse_start();
    send(mk(4'd6, 5'd5, 5'd6, 5'd7, 6'h11, 16'h1234, 26'h10), 1, 32'h0C00_0010);
    send(mk(4'd7, 5'd31, 5'd9, 5'd9, 6'h3F, 16'hFFFF, 26'h3FFFFFF), 1, 32'h03E0_0008);
    send(mk(4'd8, 5'd4, 5'd12, 5'd7, 6'h3F, 16'hFFFF, 26'h3FFFFFF), 1, 32'h0080_F809);
    send(rand_cmd(4'd9), 1, 32'hFC00_0000);
    @(negedge clk);
    check_status("s3");

    // Illegal kind writes NOP, loading continues
    pulse_start();
    send(rand_cmd(4'd12), 1, 32'h0000_0000);
    send(mk(4'd4, 5'd3, 5'd4, 5'd0, 6'd0, 16'h0007, 26'd0), 1, 32'h2064_0007);
    @(negedge clk);
    check_status("s4_mid");
    send(rand_cmd(4'd9), 1, 32'hFC00_0000);
    @(negedge clk);
    check_status("s4");

    // Capacity overflow
    pulse_start();
    for (int i = 0; i < DEPTH; i++) send(rand_cmd(4'd4), 0, 32'd0);
    @(negedge clk);
    drive(rand_cmd(4'd4));
    cmd_valid = 1'b1;
    chk("ovf.held_cmd_ready", 32'(cmd_ready), 32'd0);
    repeat (2) @(negedge clk);
    cmd_valid = 1'b0;
    check_status("ovf");

    // Reset during LOAD after two writes
    pulse_start();
    send(rand_cmd(4'd4), 0, 32'd0);
    send(rand_cmd(4'd1), 0, 32'd0);
    @(negedge clk);
    drive(rand_cmd(4'd2));
    cmd_valid = 1'b1;
    #2 rst_n = 1'b0;
    m_state = 0; m_slot = 0; m_count = 0; m_ill = 0; m_ovf = 0;
    #1;
    chk("abort.imem_we", 32'(imem_we), 32'd0);
    check_status("abort");
    chk("abort.imem_addr", 32'(imem_addr), 32'(BASE_ADDR));
    cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start();
    send(rand_cmd(4'd2), 0, 32'd0);
    @(negedge clk);
    check_status("restart_mid");
    send(rand_cmd(4'd9), 0, 32'd0);
    @(negedge clk);
    check_status("restart");

    // Randomized sessions with gaps and ignored mid-session starts
    for (int s = 0; s < 40; s++) begin
      pulse_start();
      for (int n = 0; n < 8 && m_state == 1; n++) begin
        int r;
        logic [3:0] k;
        r = $urandom_range(0, 9);
        if (r == 0) begin
          @(negedge clk);
          drive(rand_cmd(4'($urandom)));
        end else if (r == 1) begin
          pulse_start();
        end
        k = ($urandom_range(0, 5) == 0) ? 4'd9 : 4'($urandom_range(0, 15));
        send(rand_cmd(k), 0, 32'd0);
      end
      if (m_state == 1) send(rand_cmd(4'd9), 0, 32'd0);
      @(negedge clk);
      check_status("rand");
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
